input_debounce_sync: RTL and testbench



---
 rtl/input_debounce_sync.sv | 115 +++++++++++
 tb/tb_input_debounce_sync.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/input_debounce_sync.sv
// Board-input conditioner: per-channel synchronizer followed by a debounce FSM.
// Emits a clean level and one-cycle rise/fall pulses for each channel.
module input_debounce_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  localparam logic [1:0] LOW       = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0][1:0]       state_q, state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            level_d, rise_d, fall_d;

  // Stage 0 captures the raw pins; the last stage feeds the FSMs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= '0;
      cnt_q      <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_out  <= level_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  // Any opposite sample while waiting aborts to the stable state with a cleared count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_out;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (state_q[i])
        LOW: begin
          if (s[i]) begin
            state_d[i] = WAIT_HIGH;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!s[i]) begin
            state_d[i] = LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HIGH;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s[i]) begin
            state_d[i] = WAIT_LOW;
            cnt_d[i]   = CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (s[i]) begin
            state_d[i] = HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = LOW;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// Directed bench for input_debounce_sync with WIDTH=4, DB_CYCLES=4, SYNC_STAGES=2.
// Vector k drives raw_in before edge k and checks the outputs just after it.
module tb_input_debounce_sync;

  logic       clk;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  int total;
  int bad;

  typedef struct {
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs[$];

  input_debounce_sync #(
    .WIDTH      (4),
    .DB_CYCLES  (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got lvl/rise/fall=%b/%b/%b want %b/%b/%b", name,
               act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic push(input int n, input logic [3:0] raw, input logic [3:0] lvl,
                      input logic [3:0] rise, input logic [3:0] fall);
    vec_t v;
    v.raw  = raw;
    v.lvl  = lvl;
    v.rise = rise;
    v.fall = fall;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    raw_in = 4'b0000;

    // Idle, ch0 press, ch1 bounce, ch0 release, ch2+ch3 simultaneous press.
    push(20, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push(5,  4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push(1,  4'b0001, 4'b0001, 4'b0001, 4'b0000);
    push(3,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(2,  4'b0011, 4'b0001, 4'b0000, 4'b0000);
    push(1,  4'b0001, 4'b0001, 4'b0000, 4'b0000);
    push(5,  4'b0011, 4'b0001, 4'b0000, 4'b0000);
    push(1,  4'b0011, 4'b0011, 4'b0010, 4'b0000);
    push(1,  4'b0011, 4'b0011, 4'b0000, 4'b0000);
    push(5,  4'b0010, 4'b0011, 4'b0000, 4'b0000);
    push(1,  4'b0010, 4'b0010, 4'b0000, 4'b0001);
    push(1,  4'b0010, 4'b0010, 4'b0000, 4'b0000);
    push(5,  4'b1110, 4'b0010, 4'b0000, 4'b0000);
    push(1,  4'b1110, 4'b1110, 4'b1100, 4'b0000);
    push(1,  4'b1110, 4'b1110, 4'b0000, 4'b0000);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {level_out, rise_pulse, fall_pulse}, 12'h000);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      raw_in = vecs[k].raw;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), {level_out, rise_pulse, fall_pulse},
            {vecs[k].lvl, vecs[k].rise, vecs[k].fall});
    end

    // Clean restart for the reset corner cases.
    @(negedge clk);
    reset  = 1'b1;
    raw_in = 4'b0000;
    #1;
    check("reset_clears_all", {level_out, rise_pulse, fall_pulse}, 12'h000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset mid-WAIT with raw held high: full latency again from the first post-reset edge.
    @(negedge clk);
    raw_in = 4'b0001;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("reset_mid_wait", {level_out, rise_pulse, fall_pulse}, 12'h000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_edge%0d", k), {level_out, rise_pulse, fall_pulse},
            {(k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000, 4'b0000});
    end

    // Reset while HIGH: level clears with no fall pulse, before or after release.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("reset_in_high", {level_out, rise_pulse, fall_pulse}, 12'h000);
    @(negedge clk);
    raw_in = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("no_fall_after_reset%0d", k), {level_out, rise_pulse, fall_pulse}, 12'h000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
